// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single registerFile write port between NUM_REQ writeback
// sources. Each requester owns a one-entry holding slot (valid/ready
// handshake). A round-robin arbiter drains one FULL slot per cycle onto the
// write port. Decode-stage read-after-write hazards against writes still
// held in slots are flagged on raw_hazard.
//
// Optional feature macro: RF_WRITE_FWD_EN
//   defined   : rs1_data/rs2_data forward the write currently on the port;
//               the granted slot is excluded from raw_hazard.
//   undefined : rs1_data/rs2_data pass rf_rs1_data/rf_rs2_data through;
//               raw_hazard also covers the granted slot.
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   req_valid/req_ready        per-requester handshake
//   req_addr/req_data          packed, requester i at [i*W +: W]
//   rf_writeEnable/rf_addr_write/rf_write_data  registerFile write port
//   grant_id                   slot driving the write port this cycle
//   addr_rs1/addr_rs2          decode read addresses
//   rf_rs1_data/rf_rs2_data    registerFile read data
//   rs1_data/rs2_data          read data to decode
//   raw_hazard                 pending write to rs1/rs2 held in a slot
// ---------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module regfile_write_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = `DATA_WIDTH,
    parameter int ADDR_W  = `REG_ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic                        rf_writeEnable,
    output logic [ADDR_W-1:0]           rf_addr_write,
    output logic [DATA_W-1:0]           rf_write_data,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    input  logic [ADDR_W-1:0]           addr_rs1,
    input  logic [ADDR_W-1:0]           addr_rs2,
    input  logic [DATA_W-1:0]           rf_rs1_data,
    input  logic [DATA_W-1:0]           rf_rs2_data,
    output logic [DATA_W-1:0]           rs1_data,
    output logic [DATA_W-1:0]           rs2_data,
    output logic                        raw_hazard
);

    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_t;

    slot_state_t          r_state     [NUM_REQ];
    slot_state_t          w_state_nxt [NUM_REQ];
    logic [ADDR_W-1:0]    r_addr      [NUM_REQ];
    logic [ADDR_W-1:0]    w_addr_nxt  [NUM_REQ];
    logic [DATA_W-1:0]    r_data      [NUM_REQ];
    logic [DATA_W-1:0]    w_data_nxt  [NUM_REQ];

    logic [GW-1:0]        r_ptr;
    logic [GW-1:0]        w_ptr_nxt;
    logic [GW-1:0]        r_last_grant;
    logic [GW-1:0]        w_last_grant_nxt;

    logic [NUM_REQ-1:0]   w_full;
    logic [NUM_REQ-1:0]   w_grant_oh;
    logic [NUM_REQ-1:0]   w_ready;
    logic [NUM_REQ-1:0]   w_accept;
    logic                 w_any_full;
    logic [GW-1:0]        w_grant;
    logic [GW:0]          w_scan;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                r_state[k] <= S_EMPTY;
                r_addr[k]  <= '0;
                r_data[k]  <= '0;
            end
            r_ptr        <= '0;
            r_last_grant <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                r_state[k] <= w_state_nxt[k];
                r_addr[k]  <= w_addr_nxt[k];
                r_data[k]  <= w_data_nxt[k];
            end
            r_ptr        <= w_ptr_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin grant, from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_full[k] = (r_state[k] == S_FULL);
        end
    end

    always_comb begin
        w_any_full = 1'b0;
        w_grant    = r_ptr;
        w_scan     = '0;
        // Visit slots ptr, ptr+1, ... modulo NUM_REQ; first FULL slot wins.
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_scan = {1'b0, r_ptr} + (GW+1)'(k);
            if (w_scan >= (GW+1)'(NUM_REQ)) begin
                w_scan = w_scan - (GW+1)'(NUM_REQ);
            end
            if (!w_any_full && w_full[w_scan[GW-1:0]]) begin
                w_any_full = 1'b1;
                w_grant    = w_scan[GW-1:0];
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_grant_oh[k] = w_any_full && (w_grant == GW'(k));
            // A slot being drained this edge may take a new entry at once.
            w_ready[k]    = !w_full[k] || w_grant_oh[k];
        end
        w_accept = req_valid & w_ready;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_ptr_nxt        = r_ptr;
        w_last_grant_nxt = r_last_grant;
        if (w_any_full) begin
            w_last_grant_nxt = w_grant;
            w_ptr_nxt = (w_grant == GW'(NUM_REQ-1)) ? '0 : w_grant + GW'(1);
        end

        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_state_nxt[k] = r_state[k];
            w_addr_nxt[k]  = r_addr[k];
            w_data_nxt[k]  = r_data[k];
            if (w_grant_oh[k]) begin
                w_state_nxt[k] = S_EMPTY;
            end
            // x0 writes complete the handshake but never occupy the slot.
            if (w_accept[k] && (req_addr[k*ADDR_W +: ADDR_W] != '0)) begin
                w_state_nxt[k] = S_FULL;
                w_addr_nxt[k]  = req_addr[k*ADDR_W +: ADDR_W];
                w_data_nxt[k]  = req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        req_ready      = reset ? '0 : w_ready;
        rf_writeEnable = w_any_full;
        rf_addr_write  = '0;
        rf_write_data  = '0;
        grant_id       = w_any_full ? w_grant : r_last_grant;
        if (w_any_full) begin
            rf_addr_write = r_addr[w_grant];
            rf_write_data = r_data[w_grant];
        end
    end

    always_comb begin
        raw_hazard = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (w_full[k] && (r_addr[k] != '0) &&
                ((r_addr[k] == addr_rs1) || (r_addr[k] == addr_rs2))) begin
`ifdef RF_WRITE_FWD_EN
                // The granted write is visible through the forwarding path.
                if (!w_grant_oh[k]) begin
                    raw_hazard = 1'b1;
                end
`else
                raw_hazard = 1'b1;
`endif
            end
        end
    end

`ifdef RF_WRITE_FWD_EN
    always_comb begin
        rs1_data = rf_rs1_data;
        rs2_data = rf_rs2_data;
        if (rf_writeEnable && (rf_addr_write == addr_rs1) && (addr_rs1 != '0)) begin
            rs1_data = rf_write_data;
        end
        if (rf_writeEnable && (rf_addr_write == addr_rs2) && (addr_rs2 != '0)) begin
            rs2_data = rf_write_data;
        end
    end
`else
    always_comb begin
        rs1_data = rf_rs1_data;
        rs2_data = rf_rs2_data;
    end
`endif

endmodule
